// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state codes and default timing constants shared by the stopwatch control slice
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, LAP = 2'd3} state_t;
  localparam int unsigned PRESCALE_DEF   = 50000;
  localparam int unsigned DB_TICKS_DEF   = 8;
  localparam int unsigned LONG_TICKS_DEF = 1500;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchronizer, tick-based debounce and rising-edge press pulse for one button
module sw_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_TICKS = DB_TICKS_DEF
) (
  input  logic clk0,
  input  logic rst,
  input  logic tick,
  input  logic sw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_TICKS + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  always_ff @(posedge clk0) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], sw};
      level_d <= level;
      if (tick) begin
        if (sync[1] == level) cnt <= '0;
        else if (cnt == CW'(DB_TICKS - 1)) begin
          cnt   <= '0;
          level <= sync[1];
        end else cnt <= cnt + 1'b1;
      end
    end
  end
  assign press = level & ~level_d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/stop and lap/reset buttons driving a Moore stopwatch FSM
// Optional long-press lap-to-IDLE abort is enabled by defining STOPWATCH_CTRL_LONGPRESS_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned PRESCALE   = PRESCALE_DEF,
  parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
  parameter int unsigned LONG_TICKS = LONG_TICKS_DEF
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic       run_en,
  output logic       clr,
  output logic       lap_hold,
  output logic [1:0] state
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pcnt;
  logic tick;
  logic [1:0] level, press;
  logic long_fire;
  state_t cur, nxt;
  assign tick = (pcnt == PW'(PRESCALE - 1));
  always_ff @(posedge clk0) begin
    if (rst) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + 1'b1;
  end
  for (genvar i = 0; i < 2; i++) begin : g_btn
    sw_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .clk0 (clk0),
      .rst  (rst),
      .tick (tick),
      .sw   (sw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
  localparam int LW = $clog2(LONG_TICKS + 1);
  logic [LW-1:0] lcnt;
  // Counts ticks of a held lap button outside IDLE; the release after an abort is a falling edge and so never a press.
  assign long_fire = tick && level[1] && cur != IDLE && lcnt == LW'(LONG_TICKS - 1);
  always_ff @(posedge clk0) begin
    if (rst || !level[1] || cur == IDLE) lcnt <= '0;
    else if (tick) lcnt <= lcnt + 1'b1;
  end
`else
  assign long_fire = 1'b0;
`endif
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE: nxt = press[0] ? RUN : IDLE;
      RUN:  nxt = press[0] ? STOP : press[1] ? LAP : RUN;
      LAP:  nxt = press[0] ? STOP : press[1] ? RUN : LAP;
      STOP: nxt = press[0] ? RUN : press[1] ? IDLE : STOP;
    endcase
    if (long_fire) nxt = IDLE;
  end
  // clr marks the first IDLE cycle after leaving any other state, and is held during reset.
  always_ff @(posedge clk0) begin
    if (rst) begin
      cur <= IDLE;
      clr <= 1'b1;
    end else begin
      cur <= nxt;
      clr <= (nxt == IDLE) && (cur != IDLE);
    end
  end
  assign run_en   = (cur == RUN) || (cur == LAP);
  assign lap_hold = (cur == LAP);
  assign state    = cur;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl with PRESCALE=4, DB_TICKS=3, LONG_TICKS=10
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;
  logic clk0 = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sw = 2'b00;
  logic run_en, clr, lap_hold;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev = 2'd0;

  stopwatch_ctrl #(.PRESCALE(4), .DB_TICKS(3), .LONG_TICKS(10)) dut (
    .clk0    (clk0),
    .rst     (rst),
    .sw      (sw),
    .run_en  (run_en),
    .clr     (clr),
    .lap_hold(lap_hold),
    .state   (state)
  );

  always #5 clk0 = ~clk0;

  always @(negedge clk0) begin
    checks++;
    if (run_en !== (state == 2'd1 || state == 2'd3) || lap_hold !== (state == 2'd3) || (clr === 1'b1 && run_en === 1'b1)) begin
      errors++;
      $display("FAIL decode: state=%0d run_en=%b lap_hold=%b clr=%b", state, run_en, lap_hold, clr);
    end
    if (state !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL transition: got state %0d, required no change from %0d", state, prev);
      end else begin
        if (state !== exp_q[0]) begin
          errors++;
          $display("FAIL transition: got state %0d, required %0d", state, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      prev = state;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk0);
  endtask

  task automatic press(input int idx, input logic [1:0] nxt);
    sw[idx] = 1'b1;
    exp_q.push_back(nxt);
    cyc(24);
    sw[idx] = 1'b0;
    cyc(24);
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if (state !== 2'd0 || run_en !== 1'b0 || lap_hold !== 1'b0 || clr !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: state=%0d run_en=%b lap_hold=%b clr=%b, required 0 0 0 1", state, run_en, lap_hold, clr);
    end
    rst = 1'b0;
    cyc(1);
    checks++;
    if (clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_clr: clr=%b required 0", clr);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 12; i++) begin
      sw[0] = ~sw[0];
      cyc(5);
    end
    sw[0] = 1'b0;
    cyc(30);
    checks++;
    if (state !== 2'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce: state=%0d required 0", state);
    end
  endtask

  task automatic test_start();
    int n = 0;
    sw[0] = 1'b1;
    exp_q.push_back(RUN);
    while (run_en !== 1'b1 && n < 40) begin
      @(negedge clk0);
      n++;
    end
    checks++;
    if (run_en !== 1'b1 || n < 11 || n > 18) begin
      errors++;
      $display("FAIL start_latency: run_en=%b after %0d cycles, required 1 within 11..18", run_en, n);
    end
    if (n < 40) cyc(40 - n);
    sw[0] = 1'b0;
    cyc(30);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL start_state: state=%0d required 1", state);
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    exp_q.push_back(IDLE);
    cyc(1);
    checks++;
    if (state !== 2'd0 || run_en !== 1'b0 || clr !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: state=%0d run_en=%b clr=%b, required 0 0 1", state, run_en, clr);
    end
    rst = 1'b0;
    cyc(1);
    checks++;
    if (clr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clr: clr=%b required 0", clr);
    end
  endtask

  task automatic test_sequence();
    int n = 0;
    press(0, RUN);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL seq_start: state=%0d required 1", state); end
    press(1, LAP);
    checks++;
    if (state !== 2'd3 || lap_hold !== 1'b1) begin errors++; $display("FAIL seq_lap: state=%0d lap_hold=%b required 3 1", state, lap_hold); end
    press(1, RUN);
    checks++;
    if (state !== 2'd1 || lap_hold !== 1'b0) begin errors++; $display("FAIL seq_unlap: state=%0d lap_hold=%b required 1 0", state, lap_hold); end
    press(0, STOP);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL seq_stop: state=%0d required 2", state); end
    sw[1] = 1'b1;
    exp_q.push_back(IDLE);
    while (state !== 2'd0 && n < 40) begin
      @(negedge clk0);
      n++;
    end
    checks++;
    if (state !== 2'd0 || clr !== 1'b1) begin errors++; $display("FAIL seq_idle_clr: state=%0d clr=%b required 0 1", state, clr); end
    cyc(1);
    checks++;
    if (clr !== 1'b0) begin errors++; $display("FAIL seq_clr_width: clr=%b required 0", clr); end
    cyc(20);
    sw[1] = 1'b0;
    cyc(24);
  endtask

  task automatic test_simultaneous();
    press(0, RUN);
    sw = 2'b11;
    exp_q.push_back(STOP);
    cyc(24);
    sw = 2'b00;
    cyc(24);
    checks++;
    if (state !== 2'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous: state=%0d required 2", state);
    end
  endtask

  task automatic test_long_press();
    int n = 0;
    press(0, RUN);
    sw[1] = 1'b1;
    exp_q.push_back(LAP);
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    exp_q.push_back(IDLE);
    while (state !== 2'd0 && n < 60) begin
      @(negedge clk0);
      n++;
    end
    checks++;
    if (state !== 2'd0 || clr !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_abort: state=%0d clr=%b required 0 1", state, clr);
    end
    cyc(1);
    checks++;
    if (clr !== 1'b0) begin errors++; $display("FAIL long_clr_width: clr=%b required 0", clr); end
    if (n < 59) cyc(59 - n);
    sw[1] = 1'b0;
    cyc(30);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL long_release: state=%0d required 0", state); end
`else
    cyc(60);
    sw[1] = 1'b0;
    cyc(30);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL long_hold_plain: state=%0d required 3", state); end
    press(1, RUN);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL long_unlap: state=%0d required 1", state); end
`endif
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_start();
    test_reset_mid_run();
    cyc(30);
    test_sequence();
    test_simultaneous();
    test_long_press();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d transitions outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
